fatori_fi_injector: RTL and testbench



---
 rtl/fatori_fi_injector.sv | 203 ++++++++++++++++++++
 tb/tb_fatori_fi_injector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fatori_fi_injector.sv
// fatori_fi_injector: fault-injection sequencer for FATORI M-of-N hardened wrappers.
// Define FATORI_FI_DELAY_EN to build the pre-injection DELAY state; otherwise cmd_delay_i is ignored.
module fatori_fi_injector #(
    parameter int unsigned FI_W    = 8,
    parameter int unsigned DUR_W   = 8,
    parameter int unsigned LAT_W   = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [FI_W-1:0]  cmd_code_i,
    input  logic [DUR_W-1:0] cmd_delay_i,
    input  logic [DUR_W-1:0] cmd_dur_i,
    output logic [FI_W-1:0]  fi_port_o,
    input  logic             min_err_i,
    input  logic             maj_err_i,
    input  logic             scrub_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [1:0]       rsp_status_o,
    output logic [LAT_W-1:0] rsp_latency_o,
    output logic             rsp_scrub_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StInject,
        StObserve,
        StResp
    } state_e;

    localparam logic [LAT_W-1:0] TimeoutVal = LAT_W'(TIMEOUT);
    localparam logic [DUR_W-1:0] DurOne     = DUR_W'(1);

    state_e           state_q, state_d;
    logic [FI_W-1:0]  code_q, code_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             det_q, det_d;
    logic [1:0]       status_q, status_d;
    logic [LAT_W-1:0] latency_q, latency_d;
    logic             scrub_q, scrub_d;
    logic [FI_W-1:0]  fi_port_q, fi_port_d;

    logic accept;
    logic window;
    logic detect_now;
    logic timeout_hit;

    assign accept      = cmd_valid_i & (state_q == StIdle);
    assign window      = (state_q == StInject) | (state_q == StObserve);
    assign detect_now  = window & (min_err_i | maj_err_i) & ~det_q;
    assign timeout_hit = (state_q == StObserve) & (lat_cnt_q == TimeoutVal);

`ifndef FATORI_FI_DELAY_EN
    logic unused_delay;
    assign unused_delay = ^cmd_delay_i;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            code_q    <= '0;
            dur_q     <= '0;
            cnt_q     <= '0;
            lat_cnt_q <= '0;
            det_q     <= 1'b0;
            status_q  <= 2'd0;
            latency_q <= '0;
            scrub_q   <= 1'b0;
            fi_port_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            dur_q     <= dur_d;
            cnt_q     <= cnt_d;
            lat_cnt_q <= lat_cnt_d;
            det_q     <= det_d;
            status_q  <= status_d;
            latency_q <= latency_d;
            scrub_q   <= scrub_d;
            fi_port_q <= fi_port_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    if (cmd_code_i == '0) begin
                        state_d = StResp;
`ifdef FATORI_FI_DELAY_EN
                    end else if (cmd_delay_i != '0) begin
                        state_d = StDelay;
`endif
                    end else begin
                        state_d = StInject;
                    end
                end
            end
`ifdef FATORI_FI_DELAY_EN
            StDelay: begin
                if (cnt_q == DurOne) begin
                    state_d = StInject;
                end
            end
`endif
            StInject: begin
                if (cnt_q == DurOne) begin
                    state_d = (det_q | detect_now) ? StResp : StObserve;
                end
            end
            StObserve: begin
                if (detect_now || timeout_hit) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: command latch, counters, detection capture
    always_comb begin
        code_d    = code_q;
        dur_d     = dur_q;
        cnt_d     = cnt_q;
        lat_cnt_d = lat_cnt_q;
        det_d     = det_q;
        status_d  = status_q;
        latency_d = latency_q;
        scrub_d   = scrub_q;

        if (accept) begin
            code_d    = cmd_code_i;
            dur_d     = (cmd_dur_i == '0) ? DurOne : cmd_dur_i;
            det_d     = 1'b0;
            scrub_d   = 1'b0;
            latency_d = '0;
            status_d  = (cmd_code_i == '0) ? 2'd3 : 2'd0;
`ifdef FATORI_FI_DELAY_EN
            cnt_d     = cmd_delay_i;
`endif
        end

`ifdef FATORI_FI_DELAY_EN
        if (state_q == StDelay) begin
            cnt_d = cnt_q - DurOne;
        end
`endif

        if (window) begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
            scrub_d   = scrub_q | scrub_i;
            if (state_q == StInject) begin
                cnt_d = cnt_q - DurOne;
            end
        end

        // First detection wins; later flags are ignored once det_q is set
        if (detect_now) begin
            det_d     = 1'b1;
            latency_d = lat_cnt_q;
            status_d  = maj_err_i ? 2'd2 : 2'd1;
        end else if (timeout_hit) begin
            latency_d = lat_cnt_q;
        end

        if ((state_d == StInject) && (state_q != StInject)) begin
            lat_cnt_d = '0;
            cnt_d     = dur_d;
        end
    end

    // Fault bus is registered off the next state so the code lines up with INJECT exactly
    always_comb begin
        fi_port_d = (state_d == StInject) ? code_d : '0;
    end

    // Output logic
    always_comb begin
        cmd_ready_o   = (state_q == StIdle);
        busy_o        = (state_q != StIdle);
        rsp_valid_o   = (state_q == StResp);
        rsp_status_o  = status_q;
        rsp_latency_o = latency_q;
        rsp_scrub_o   = scrub_q;
        fi_port_o     = fi_port_q;
    end

endmodule

// File: tb/tb_fatori_fi_injector.sv
// Directed self-checking bench for fatori_fi_injector.
// Delay expectations follow FATORI_FI_DELAY_EN in the same way as the design build.
module tb_fatori_fi_injector;

    localparam int FI_W    = 8;
    localparam int DUR_W   = 8;
    localparam int LAT_W   = 16;
    localparam int TIMEOUT = 1023;

`ifdef FATORI_FI_DELAY_EN
    localparam bit DelayEn = 1'b1;
`else
    localparam bit DelayEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [FI_W-1:0]  cmd_code;
    logic [DUR_W-1:0] cmd_delay;
    logic [DUR_W-1:0] cmd_dur;
    logic [FI_W-1:0]  fi_port;
    logic             min_err;
    logic             maj_err;
    logic             scrub;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_status;
    logic [LAT_W-1:0] rsp_latency;
    logic             rsp_scrub;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fatori_fi_injector #(
        .FI_W   (FI_W),
        .DUR_W  (DUR_W),
        .LAT_W  (LAT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_code_i   (cmd_code),
        .cmd_delay_i  (cmd_delay),
        .cmd_dur_i    (cmd_dur),
        .fi_port_o    (fi_port),
        .min_err_i    (min_err),
        .maj_err_i    (maj_err),
        .scrub_i      (scrub),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_status_o (rsp_status),
        .rsp_latency_o(rsp_latency),
        .rsp_scrub_o  (rsp_scrub),
        .busy_o       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] code, input logic [7:0] dly, input logic [7:0] dur);
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_delay = dly;
        cmd_dur   = dur;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_code  = '0;
        cmd_delay = '0;
        cmd_dur   = '0;
        min_err   = 1'b0;
        maj_err   = 1'b0;
        scrub     = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_fi_port", 32'(fi_port), 32'd0);
        check("rst_status", 32'(rsp_status), 32'd0);
        check("rst_latency", 32'(rsp_latency), 32'd0);
        check("rst_scrub", 32'(rsp_scrub), 32'd0);
        rst_n = 1'b1;
        step();

        // Minority detection; a majority flag during IDLE must be ignored
        maj_err = 1'b1;
        send(8'h05, 8'd0, 8'd1);
        maj_err = 1'b0;
        check("min_fi_inj0", 32'(fi_port), 32'h05);
        check("min_ready_low", 32'(cmd_ready), 32'd0);
        check("min_busy", 32'(busy), 32'd1);
        step();
        check("min_fi_obs1", 32'(fi_port), 32'h00);
        step();
        min_err = 1'b1;
        step();
        min_err = 1'b0;
        check("min_rsp_valid", 32'(rsp_valid), 32'd1);
        check("min_status", 32'(rsp_status), 32'd1);
        check("min_latency", 32'(rsp_latency), 32'd2);
        check("min_scrub", 32'(rsp_scrub), 32'd0);
        handshake("min");

        // Majority priority with optional delay
        d = DelayEn ? 3 : 0;
        send(8'hA3, 8'd3, 8'd4);
        for (int i = 0; i < d; i++) begin
            check("maj_fi_delay", 32'(fi_port), 32'h00);
            step();
        end
        check("maj_fi_inj0", 32'(fi_port), 32'hA3);
        step();
        min_err = 1'b1;
        maj_err = 1'b1;
        check("maj_fi_inj1", 32'(fi_port), 32'hA3);
        step();
        min_err = 1'b0;
        maj_err = 1'b0;
        check("maj_fi_inj2", 32'(fi_port), 32'hA3);
        check("maj_no_early_rsp", 32'(rsp_valid), 32'd0);
        step();
        check("maj_fi_inj3", 32'(fi_port), 32'hA3);
        step();
        check("maj_rsp_valid", 32'(rsp_valid), 32'd1);
        check("maj_fi_after", 32'(fi_port), 32'h00);
        check("maj_status", 32'(rsp_status), 32'd2);
        check("maj_latency", 32'(rsp_latency), 32'd1);
        handshake("maj");

        // Timeout with scrub seen in OBSERVE
        send(8'h11, 8'd0, 8'd4);
        check("to_fi_inj0", 32'(fi_port), 32'h11);
        for (int i = 0; i < 4; i++) step();
        check("to_fi_obs", 32'(fi_port), 32'h00);
        scrub = 1'b1;
        step();
        scrub = 1'b0;
        n = 0;
        while (!rsp_valid && n < 2000) begin
            step();
            n++;
        end
        check("to_cycles", 32'(n), 32'd1019);
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_status", 32'(rsp_status), 32'd0);
        check("to_latency", 32'(rsp_latency), 32'd1023);
        check("to_scrub", 32'(rsp_scrub), 32'd1);
        handshake("to");

        // Illegal command with back-pressure; a second command must wait
        send(8'h00, 8'd2, 8'd3);
        check("ill_rsp_valid", 32'(rsp_valid), 32'd1);
        check("ill_status", 32'(rsp_status), 32'd3);
        check("ill_latency", 32'(rsp_latency), 32'd0);
        check("ill_scrub_cleared", 32'(rsp_scrub), 32'd0);
        cmd_valid = 1'b1;
        cmd_code  = 8'h66;
        for (int i = 0; i < 10; i++) begin
            check("bp_fi", 32'(fi_port), 32'h00);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_status", 32'(rsp_status), 32'd3);
            check("bp_ready_low", 32'(cmd_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("bp_ready_after", 32'(cmd_ready), 32'd1);
        check("bp_busy_after", 32'(busy), 32'd0);
        step();
        check("bp_no_accept", 32'(busy), 32'd0);

        // Reset mid-INJECT
        send(8'h3C, 8'd0, 8'd8);
        step();
        step();
        check("rst_mid_fi_before", 32'(fi_port), 32'h3C);
        rst_n = 1'b0;
        step();
        check("rst_mid_fi", 32'(fi_port), 32'h00);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Delay 5, dur 2: immediate injection unless the delay feature is built
        d = DelayEn ? 5 : 0;
        send(8'h77, 8'd5, 8'd2);
        for (int i = 0; i < d; i++) begin
            check("dly_fi_delay", 32'(fi_port), 32'h00);
            step();
        end
        check("dly_fi_inj0", 32'(fi_port), 32'h77);
        step();
        check("dly_fi_inj1", 32'(fi_port), 32'h77);
        step();
        check("dly_fi_obs", 32'(fi_port), 32'h00);
        maj_err = 1'b1;
        step();
        maj_err = 1'b0;
        check("dly_status", 32'(rsp_status), 32'd2);
        check("dly_latency", 32'(rsp_latency), 32'd2);
        handshake("dly");

        // Duration 0 behaves as 1; detection in the only inject cycle
        send(8'h42, 8'd0, 8'd0);
        min_err = 1'b1;
        check("dur0_fi_inj0", 32'(fi_port), 32'h42);
        step();
        min_err = 1'b0;
        check("dur0_rsp_valid", 32'(rsp_valid), 32'd1);
        check("dur0_fi_after", 32'(fi_port), 32'h00);
        check("dur0_status", 32'(rsp_status), 32'd1);
        check("dur0_latency", 32'(rsp_latency), 32'd0);
        handshake("dur0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
